// File: rtl/sar_search_engine.sv
// ----------------------------------------------------------------------------
// sar_search_engine
//
// Successive-approximation (binary search) initiator. It presents a probe
// value to an external magnitude comparator, consumes the eq/lt/gt verdict
// of probe against a hidden target, and narrows the search interval until
// the target is hit or the interval is empty.
//
// The interval is [lo, hi) with an exclusive upper bound. Both bounds are
// W+1 bits wide, so hi can hold 2^W and neither bound can wrap.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        begin a search (sampled only in IDLE)
//   abort        terminate an active search
//   probe        value driven to comparator input a
//   probe_valid  probe is stable and a verdict is requested
//   cmp_valid    comparator verdict valid this cycle
//   cmp_eq       probe == target
//   cmp_lt       probe <  target
//   cmp_gt       probe >  target
//   busy         search in progress
//   done         one-cycle pulse when a search ends (any outcome)
//   found        last search hit eq; held until next start
//   error        last search aborted or saw an illegal verdict; held
//   result       matched value when found, else last probe; held
//   iter_count   probes issued in current/last search; held
// ----------------------------------------------------------------------------
module sar_search_engine #(
    parameter int W  = 20,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic [W-1:0]  probe,
    output logic          probe_valid,
    input  logic          cmp_valid,
    input  logic          cmp_eq,
    input  logic          cmp_lt,
    input  logic          cmp_gt,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic          error,
    output logic [W-1:0]  result,
    output logic [CW-1:0] iter_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROBE  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Full search space is [0, 2^W); the first probe is its midpoint.
    localparam logic [W:0]   SPAN        = {1'b1, {W{1'b0}}};
    localparam logic [W-1:0] FIRST_PROBE = {1'b1, {(W-1){1'b0}}};

    state_t        state_q;
    logic [W:0]    lo_q;
    logic [W:0]    hi_q;
    logic [W-1:0]  probe_q;
    logic          probe_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          found_q;
    logic          error_q;
    logic [W-1:0]  result_q;
    logic [CW-1:0] iter_q;

    logic [W:0]    lo_d;
    logic [W:0]    hi_d;
    logic [W-1:0]  mid_d;
    logic          space_empty;
    logic          verdict_legal;

    // Exactly one of eq/lt/gt must be asserted for a verdict to be usable.
    assign verdict_legal = ( cmp_eq & ~cmp_lt & ~cmp_gt) |
                           (~cmp_eq &  cmp_lt & ~cmp_gt) |
                           (~cmp_eq & ~cmp_lt &  cmp_gt);

    // Candidate bounds after the current verdict. probe_q always holds the
    // current mid, which is strictly below hi and therefore fits in W bits.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (cmp_lt) begin
            lo_d = {1'b0, probe_q} + (W+1)'(1);
        end else if (cmp_gt) begin
            hi_d = {1'b0, probe_q};
        end
        // mid < hi <= 2^W, so the truncation to W bits never drops a one.
        mid_d       = W'(lo_d + ((hi_d - lo_d) >> 1));
        space_empty = (lo_d == hi_d);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            lo_q          <= '0;
            hi_q          <= '0;
            probe_q       <= '0;
            probe_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            error_q       <= 1'b0;
            result_q      <= '0;
            iter_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        lo_q          <= '0;
                        hi_q          <= SPAN;
                        found_q       <= 1'b0;
                        error_q       <= 1'b0;
                        iter_q        <= CW'(1);
                        probe_q       <= FIRST_PROBE;
                        probe_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= ST_PROBE;
                    end
                end

                ST_PROBE: begin
                    if (abort) begin
                        // Abort wins over any verdict arriving this cycle.
                        found_q       <= 1'b0;
                        error_q       <= 1'b1;
                        result_q      <= probe_q;
                        probe_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        state_q       <= ST_FINISH;
                    end else if (cmp_valid) begin
                        if (!verdict_legal) begin
                            error_q       <= 1'b1;
                            result_q      <= probe_q;
                            probe_valid_q <= 1'b0;
                            busy_q        <= 1'b0;
                            done_q        <= 1'b1;
                            state_q       <= ST_FINISH;
                        end else if (cmp_eq) begin
                            found_q       <= 1'b1;
                            result_q      <= probe_q;
                            probe_valid_q <= 1'b0;
                            busy_q        <= 1'b0;
                            done_q        <= 1'b1;
                            state_q       <= ST_FINISH;
                        end else begin
                            lo_q <= lo_d;
                            hi_q <= hi_d;
                            if (space_empty) begin
                                // Target absent: report the last probe tried.
                                result_q      <= probe_q;
                                probe_valid_q <= 1'b0;
                                busy_q        <= 1'b0;
                                done_q        <= 1'b1;
                                state_q       <= ST_FINISH;
                            end else begin
                                probe_q <= mid_d;
                                iter_q  <= iter_q + CW'(1);
                            end
                        end
                    end
                end

                ST_FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    probe_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign probe       = probe_q;
    assign probe_valid = probe_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign error       = error_q;
    assign result      = result_q;
    assign iter_count  = iter_q;

endmodule

// File: tb/tb_sar_search_engine.sv
// ----------------------------------------------------------------------------
// tb_sar_search_engine
//
// Directed bench for sar_search_engine (W=20, CW=5). A behavioural
// comparator answers the probe; it can compare against a target, always
// answer gt or lt, inject an illegal lt+gt verdict on the second verdict,
// or be forced to eq. Inputs change 1ns after the rising edge; outputs are
// sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_sar_search_engine;

    localparam int W  = 20;
    localparam int CW = 5;

    localparam int M_CMP = 0;
    localparam int M_GT  = 1;
    localparam int M_LT  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [W-1:0]  probe;
    logic          probe_valid;
    logic          cmp_valid;
    logic          cmp_eq;
    logic          cmp_lt;
    logic          cmp_gt;
    logic          busy;
    logic          done;
    logic          found;
    logic          error;
    logic [W-1:0]  result;
    logic [CW-1:0] iter_count;

    // comparator model controls
    logic [W-1:0] target;
    int           mode;
    int           pace;
    bit           illegal_en;
    bit           force_eq;
    int           pace_cnt;
    int           verdict_num;

    // monitors
    int           stable_viol;
    int           done_cnt;
    logic         prev_pv;
    logic         prev_acc;
    logic [W-1:0] prev_probe;

    int checks   = 0;
    int failures = 0;

    sar_search_engine #(.W(W), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .probe       (probe),
        .probe_valid (probe_valid),
        .cmp_valid   (cmp_valid),
        .cmp_eq      (cmp_eq),
        .cmp_lt      (cmp_lt),
        .cmp_gt      (cmp_gt),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .error       (error),
        .result      (result),
        .iter_count  (iter_count)
    );

    always #5 clk = ~clk;

    // Comparator: same-cycle combinational response.
    always_comb begin
        cmp_eq = 1'b0;
        cmp_lt = 1'b0;
        cmp_gt = 1'b0;
        if (force_eq) begin
            cmp_eq = 1'b1;
        end else if (illegal_en && verdict_num == 1) begin
            cmp_lt = 1'b1;
            cmp_gt = 1'b1;
        end else if (mode == M_GT) begin
            cmp_gt = 1'b1;
        end else if (mode == M_LT) begin
            cmp_lt = 1'b1;
        end else begin
            cmp_eq = (probe == target);
            cmp_lt = (probe <  target);
            cmp_gt = (probe >  target);
        end
    end

    assign cmp_valid = (pace_cnt == 0);

    always @(posedge clk) begin
        pace_cnt <= (pace_cnt + 1 >= pace) ? 0 : pace_cnt + 1;
        if (rst || (start && !busy))
            verdict_num <= 0;
        else if (probe_valid && cmp_valid)
            verdict_num <= verdict_num + 1;
    end

    // Probe must not move while a verdict is outstanding; count done pulses.
    initial begin
        stable_viol = 0;
        done_cnt    = 0;
        prev_pv     = 1'b0;
        prev_acc    = 1'b0;
        prev_probe  = '0;
        pace_cnt    = 0;
        verdict_num = 0;
    end

    always @(negedge clk) begin
        if (prev_pv && !prev_acc && probe_valid && probe != prev_probe)
            stable_viol = stable_viol + 1;
        if (done)
            done_cnt = done_cnt + 1;
        prev_pv    = probe_valid;
        prev_acc   = probe_valid && (cmp_valid || abort);
        prev_probe = probe;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_search();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen)
            check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic set_model(input logic [W-1:0] t, input int m, input int p, input bit ill);
        target     = t;
        mode       = m;
        pace       = p;
        illegal_en = ill;
        force_eq   = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] target;
        int           mode;
        int           pace;
        bit           illegal;
        bit           exp_found;
        bit           exp_error;
        logic [W-1:0] exp_result;
        int           exp_iter;
    } vec_t;

    vec_t vecs[10];

    initial begin
        bit           seen;
        logic [W-1:0] exp_probe;
        logic [W-1:0] last_probe;
        int           incr_viol;
        int           nprobes;
        int           mono_viol;
        int           prev_iter;
        int           done_before;

        // target, mode, pace, illegal, found, error, result, iter
        vecs[0] = '{20'd524288,  M_CMP, 1, 1'b0, 1'b1, 1'b0, 20'd524288,  1};
        vecs[1] = '{20'd0,       M_CMP, 1, 1'b0, 1'b1, 1'b0, 20'd0,       21};
        vecs[2] = '{20'd1048575, M_CMP, 1, 1'b0, 1'b1, 1'b0, 20'd1048575, 20};
        vecs[3] = '{20'd0,       M_GT,  1, 1'b0, 1'b0, 1'b0, 20'd0,       21};
        vecs[4] = '{20'd0,       M_LT,  1, 1'b0, 1'b0, 1'b0, 20'd1048575, 20};
        vecs[5] = '{20'd777,     M_CMP, 3, 1'b0, 1'b1, 1'b0, 20'd777,     20};
        vecs[6] = '{20'd262144,  M_CMP, 1, 1'b0, 1'b1, 1'b0, 20'd262144,  2};
        vecs[7] = '{20'd786432,  M_CMP, 1, 1'b0, 1'b1, 1'b0, 20'd786432,  2};
        vecs[8] = '{20'd1,       M_CMP, 1, 1'b0, 1'b1, 1'b0, 20'd1,       20};
        vecs[9] = '{20'd777,     M_CMP, 3, 1'b1, 1'b0, 1'b1, 20'd262144,  2};

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_model('0, M_CMP, 1, 1'b0);

        // reset state
        #3;
        check("rst_probe",       32'(probe),       32'd0);
        check("rst_probe_valid", 32'(probe_valid), 32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_done",        32'(done),        32'd0);
        check("rst_found",       32'(found),       32'd0);
        check("rst_error",       32'(error),       32'd0);
        check("rst_result",      32'(result),      32'd0);
        check("rst_iter",        32'(iter_count),  32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // table-driven searches
        for (int v = 0; v < 10; v++) begin
            set_model(vecs[v].target, vecs[v].mode, vecs[v].pace, vecs[v].illegal);
            start_search();
            check($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
            wait_done(200, seen);
            if (seen) begin
                check($sformatf("v%0d_found", v),  32'(found),      32'(vecs[v].exp_found));
                check($sformatf("v%0d_error", v),  32'(error),      32'(vecs[v].exp_error));
                check($sformatf("v%0d_result", v), 32'(result),     32'(vecs[v].exp_result));
                check($sformatf("v%0d_iter", v),   32'(iter_count), 32'(vecs[v].exp_iter));
                check($sformatf("v%0d_pv_off", v), 32'(probe_valid), 32'd0);
                @(negedge clk);
                check($sformatf("v%0d_done_1cyc", v), 32'(done),  32'd0);
                check($sformatf("v%0d_hold_res", v),  32'(result), 32'(vecs[v].exp_result));
            end
            tick();
        end
        check("probe_stable_viol", stable_viol, 0);

        // target 0: exact probe sequence, one probe per cycle
        set_model(20'd0, M_CMP, 1, 1'b0);
        start_search();
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            exp_probe = (i < 20) ? (20'd1 << (19 - i)) : 20'd0;
            check($sformatf("seq0_probe%0d", i), 32'(probe), 32'(exp_probe));
        end
        @(negedge clk);
        check("seq0_done", 32'(done), 32'd1);
        tick();

        // max target: probes strictly increasing
        set_model(20'd1048575, M_CMP, 1, 1'b0);
        start_search();
        incr_viol = 0;
        nprobes   = 0;
        last_probe = '0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (probe_valid) begin
                if (nprobes > 0 && probe <= last_probe)
                    incr_viol = incr_viol + 1;
                last_probe = probe;
                nprobes    = nprobes + 1;
            end
        end
        check("max_done_seen", 32'(seen), 32'd1);
        check("max_increasing_viol", incr_viol, 0);
        check("max_result", 32'(result), 32'd1048575);
        tick();

        // abort on the 4th probe with a simultaneous eq
        set_model(20'd5, M_CMP, 1, 1'b0);
        start_search();
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (iter_count == CW'(4)) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_reach_iter4", 32'(seen), 32'd1);
        abort    = 1'b1;
        force_eq = 1'b1;
        tick();
        abort    = 1'b0;
        force_eq = 1'b0;
        @(negedge clk);
        check("abort_done",  32'(done),  32'd1);
        check("abort_error", 32'(error), 32'd1);
        check("abort_found", 32'(found), 32'd0);
        check("abort_iter",  32'(iter_count), 32'd4);
        tick();

        // start pulses while busy are ignored
        set_model(20'd777, M_CMP, 3, 1'b0);
        start_search();
        mono_viol = 0;
        prev_iter = 1;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (int'(iter_count) < prev_iter)
                mono_viol = mono_viol + 1;
            prev_iter = int'(iter_count);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            start = (k == 4 || k == 10 || k == 11 || k == 30);
        end
        start = 1'b0;
        check("busy_start_done",  32'(seen), 32'd1);
        check("busy_start_mono",  mono_viol, 0);
        check("busy_start_found", 32'(found), 32'd1);
        check("busy_start_result", 32'(result), 32'd777);
        check("busy_start_iter",  32'(iter_count), 32'd20);
        tick();

        // reset mid-search: immediate clear, no done pulse, then a fresh search
        set_model(20'd0, M_CMP, 1, 1'b0);
        start_search();
        for (int i = 0; i < 5; i++) @(negedge clk);
        done_before = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy",   32'(busy),        32'd0);
        check("midrst_pv",     32'(probe_valid), 32'd0);
        check("midrst_probe",  32'(probe),       32'd0);
        check("midrst_result", 32'(result),      32'd0);
        check("midrst_iter",   32'(iter_count),  32'd0);
        check("midrst_done",   32'(done),        32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("midrst_no_done_pulse", done_cnt, done_before);
        tick();
        set_model(20'd524288, M_CMP, 1, 1'b0);
        start_search();
        wait_done(50, seen);
        check("post_rst_found",  32'(found),      32'd1);
        check("post_rst_result", 32'(result),     32'd524288);
        check("post_rst_iter",   32'(iter_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=%0d", $time, 200000);
        $fatal(1);
    end

endmodule

// File: doc/sar_search_engine.md
Name: sar_search_engine

Overview:
Binary-search (successive-approximation) initiator that drives a W-bit probe value into an external magnitude comparator. It consumes the comparator's eq/lt/gt verdict of probe against a hidden target and converges on the target value. It is the questioning side of the comparator: the comparator answers, this block asks. Typical use is threshold search, calibration trims, and lookup against a monotonic reference.

Parameters:
W, 20, width of probe/result; search space is [0, 2^W-1]
CW, 5, width of iter_count; must satisfy 2^CW > W+1

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a search; sampled only in IDLE
abort  input  1  terminate an active search
probe  output  W  value presented to comparator input a (target on b)
probe_valid  output  1  probe is stable and a verdict is requested
cmp_valid  input  1  comparator verdict valid this cycle
cmp_eq  input  1  probe == target
cmp_lt  input  1  probe < target
cmp_gt  input  1  probe > target
busy  output  1  search in progress (PROBE state)
done  output  1  one-cycle pulse: search finished (any outcome)
found  output  1  last search hit eq; held until next start
error  output  1  last search aborted or saw illegal verdict; held until next start
result  output  W  matched value when found=1, else last probe; held
iter_count  output  CW  probes issued in current/last search; held

Behaviour:
- Reset (async, rst=1): state=IDLE; probe=0, probe_valid=0, busy=0, done=0, found=0, error=0, result=0, iter_count=0; lo=0, hi=0.
- Internal bounds: lo and hi are W+1 bits wide; hi is an exclusive upper bound. mid = lo + ((hi - lo) >> 1), truncated to W bits for probe. No underflow or overflow is possible.
- States: IDLE, PROBE, FINISH.
- IDLE: on start=1, load lo=0, hi=2^W, clear found/error, set iter_count=1, go to PROBE. First probe = 2^(W-1) (524288 for W=20), driven in the cycle after start. Start is ignored outside IDLE.
- PROBE: probe_valid=1 and busy=1. probe is stable until a verdict is accepted. A verdict is accepted on the rising edge where probe_valid=1 and cmp_valid=1; a same-cycle combinational response is legal. With cmp_valid tied high, the block issues one probe per cycle.
  - eq: found=1, result=probe, go to FINISH.
  - lt: lo=mid+1.
  - gt: hi=mid.
  - After an lt/gt update: if new lo==hi, the space is empty; found=0, result=probe, go to FINISH. Otherwise stay in PROBE with the new mid and iter_count+1.
  - Illegal verdict (not exactly one of eq/lt/gt high while cmp_valid=1): error=1, result=probe, go to FINISH.
- Worst-case probe count is W+1 (21 for W=20). iter_count never exceeds W+1.
- abort=1 in PROBE: go to FINISH with error=1 and found=0; takes priority over a simultaneous verdict. abort in IDLE or FINISH has no effect.
- FINISH: done=1 for exactly one cycle, probe_valid=0, busy=0, then IDLE. Outputs found, error, result and iter_count persist until the next accepted start.
- Verdict inputs are ignored whenever probe_valid=0.
- rst asserted mid-search: immediate return to the reset values; no done pulse is generated.

Test Plan:
- Comparator model, target=524288, cmp_valid=1 -> first probe 524288; done after 1 probe; found=1, result=524288, iter_count=1.
- Target=0 -> probes 524288, 262144, ..., 1, 0 in consecutive cycles; found=1, result=0, iter_count=21.
- Target=1048575 -> probes strictly increasing; found=1, result=1048575, iter_count<=21; no overflow of lo/hi.
- Model always answers gt (target absent) -> after 21 probes lo==hi; done pulse with found=0, error=0, result=0. Repeat with always-lt -> result=1048575.
- cmp_valid asserted only every 3rd cycle with target=777 -> probe held stable between verdicts; found=1, result=777. Inject lt+gt together on the 2nd verdict -> error=1, found=0, done pulse.
- Cases for abort, start and reset:
  - abort on the 4th probe with a simultaneous eq -> error=1, found=0.
  - start pulses while busy -> ignored.
  - rst mid-search -> all outputs 0 asynchronously, no done pulse; a fresh start then succeeds.
